// File: rtl/ac_motor_triangle_pkg.sv
// Shared widths, phase limits and direction/state encodings for the AC-motor triangle carrier.
package ac_motor_pkg;
  localparam int CNT_W     = 12;
  localparam int AMP_W     = 5;
  localparam int TRI_W     = AMP_W + CNT_W;
  localparam int PHASE_MAX = 2 ** (CNT_W - 1) - 1;

  localparam logic signed [CNT_W-1:0] PH_POS  = CNT_W'(PHASE_MAX);
  localparam logic signed [CNT_W-1:0] PH_NEG  = -PH_POS;
  localparam logic signed [CNT_W-1:0] PH_ONE  = CNT_W'(1);
  localparam logic signed [CNT_W-1:0] PH_ZERO = '0;

  typedef enum logic [1:0] {DIR_STOP, DIR_CW, DIR_CCW} dir_t;
  typedef enum logic [1:0] {ST_STOP, ST_CW, ST_CCW, ST_DEAD} st_t;

  function automatic dir_t decode_dir(input logic cw, input logic ccw);
    if (cw & ~ccw) return DIR_CW;
    if (ccw & ~cw) return DIR_CCW;
    return DIR_STOP;
  endfunction
endpackage

// File: rtl/ac_motor_tri_phase.sv
// Symmetric up/down phase counter bouncing between +PHASE_MAX and -PHASE_MAX; flags phase==0.
module ac_motor_tri_phase
  import ac_motor_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  output logic signed [CNT_W-1:0] phase_o,
  output logic                    zero_x_o
);
  logic signed [CNT_W-1:0] phase_q, phase_d;
  logic                    up_q, up_d;

  // Turn around on the peak itself so -2**(CNT_W-1) is never reached.
  always_comb begin
    up_d    = up_q;
    phase_d = phase_q;
    if (up_q) begin
      if (phase_q == PH_POS) begin
        up_d    = 1'b0;
        phase_d = phase_q - PH_ONE;
      end else begin
        phase_d = phase_q + PH_ONE;
      end
    end else begin
      if (phase_q == PH_NEG) begin
        up_d    = 1'b1;
        phase_d = phase_q + PH_ONE;
      end else begin
        phase_d = phase_q - PH_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= PH_ZERO;
      up_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      up_q    <= up_d;
    end
  end

  assign phase_o  = phase_q;
  assign zero_x_o = (phase_q == PH_ZERO);
endmodule

// File: rtl/ac_motor_triangle.sv
// Scaled triangle carrier with zero-crossing amplitude latch and interlocked CW/CCW direction FSM.
// Optional reversal dead time: define AC_MOTOR_TRIANGLE_DEADTIME_EN.
module ac_motor_triangle
  import ac_motor_pkg::*;
`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
  #(parameter int DEADTIME = 16)
`endif
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cw_in,
  input  logic                    ccw_in,
  input  logic [AMP_W-1:0]        amplitude,
  output logic                    cw_out,
  output logic                    ccw_out,
  output logic signed [TRI_W-1:0] triangle
);
  logic signed [CNT_W-1:0] phase;
  logic                    zero_x;
  logic [AMP_W-1:0]        amp_q, amp_d;
  logic signed [TRI_W-1:0] tri_q, tri_d;
  st_t                     state_q, state_d;
  dir_t                    req;
  logic                    cw_q, ccw_q;
`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
  localparam int DT_W = $clog2(DEADTIME + 1);
  dir_t            pend_q, pend_d;
  logic [DT_W-1:0] dcnt_q, dcnt_d;
`endif

  ac_motor_tri_phase u_phase (
    .clk_i    (clk),
    .reset_i  (reset),
    .phase_o  (phase),
    .zero_x_o (zero_x)
  );

  assign req = decode_dir(cw_in, ccw_in);

  // Amplitude is unsigned: zero-extend before the signed multiply.
  always_comb begin
    amp_d = zero_x ? amplitude : amp_q;
    tri_d = TRI_W'(phase) * $signed({{(TRI_W-AMP_W){1'b0}}, amp_q});
  end

  // STOP is immediate; direction changes wait for a carrier zero crossing.
  always_comb begin
    state_d = state_q;
`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
    pend_d  = pend_q;
    dcnt_d  = dcnt_q;
`endif
    if (req == DIR_STOP) begin
      state_d = ST_STOP;
    end
`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
    else if (state_q == ST_DEAD) begin
      if (dcnt_q == '0) state_d = (pend_q == DIR_CW) ? ST_CW : ST_CCW;
      else              dcnt_d  = dcnt_q - DT_W'(1);
    end else if (zero_x && ((state_q == ST_CW  && req == DIR_CCW) ||
                            (state_q == ST_CCW && req == DIR_CW))) begin
      state_d = ST_DEAD;
      pend_d  = req;
      dcnt_d  = DT_W'(DEADTIME - 1);
    end
`endif
    else if (zero_x) begin
      state_d = (req == DIR_CW) ? ST_CW : ST_CCW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      amp_q   <= '0;
      tri_q   <= '0;
      state_q <= ST_STOP;
      cw_q    <= 1'b0;
      ccw_q   <= 1'b0;
`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
      pend_q  <= DIR_STOP;
      dcnt_q  <= '0;
`endif
    end else begin
      amp_q   <= amp_d;
      tri_q   <= tri_d;
      state_q <= state_d;
      cw_q    <= (state_d == ST_CW);
      ccw_q   <= (state_d == ST_CCW);
`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
      pend_q  <= pend_d;
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  assign triangle = tri_q;
  assign cw_out   = cw_q;
  assign ccw_out  = ccw_q;
endmodule

// File: tb/tb_ac_motor_triangle.sv
// Self-checking bench for ac_motor_triangle: index-based carrier model plus directed and random stimulus.
module tb_ac_motor_triangle;
  logic               clk = 1'b0;
  logic               reset;
  logic               cw_in, ccw_in;
  logic [4:0]         amplitude;
  logic               cw_out, ccw_out;
  logic signed [16:0] triangle;

`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
  localparam int DEADTIME = 16;
`endif
  localparam int PERIOD = 8188;

  ac_motor_triangle dut (
    .clk       (clk),
    .reset     (reset),
    .cw_in     (cw_in),
    .ccw_in    (ccw_in),
    .amplitude (amplitude),
    .cw_out    (cw_out),
    .ccw_out   (ccw_out),
    .triangle  (triangle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Carrier phase as a closed-form function of cycles since reset.
  function automatic int phase_at(input int n);
    int m;
    m = n % PERIOD;
    if (m <= 2047) return m;
    if (m <= 6141) return 4094 - m;
    return m - PERIOD;
  endfunction

  int m_n, m_amp, m_tri, m_dead, m_pend;
  bit m_cw, m_ccw, m_valid = 0;

  always @(posedge clk) begin
    int ph, req, cur;
    ph  = phase_at(m_n);
    req = (cw_in && !ccw_in) ? 1 : (ccw_in && !cw_in) ? 2 : 0;
    cur = m_cw ? 1 : m_ccw ? 2 : 0;
    if (reset) begin
      m_valid = 1; m_n = 0; m_amp = 0; m_tri = 0;
      m_cw = 0; m_ccw = 0; m_dead = 0; m_pend = 0;
    end else begin
      m_tri = ph * m_amp;
      if (ph == 0) m_amp = int'(amplitude);
      if (req == 0) begin
        m_cw = 0; m_ccw = 0; m_dead = 0;
      end
`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
      else if (m_dead > 0) begin
        m_dead--;
        if (m_dead == 0) begin m_cw = (m_pend == 1); m_ccw = (m_pend == 2); end
      end else if (ph == 0 && cur != 0 && req != cur) begin
        m_cw = 0; m_ccw = 0; m_dead = DEADTIME; m_pend = req;
      end
`endif
      else if (ph == 0) begin
        m_cw = (req == 1); m_ccw = (req == 2);
      end
      m_n++;
    end
    if (cur == 3) $display("unreachable");
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("triangle", triangle, m_tri);
      check("cw_out", cw_out, int'(m_cw));
      check("ccw_out", ccw_out, int'(m_ccw));
      check("interlock", cw_out & ccw_out, 0);
      check("range", int'(triangle > 63457 || triangle < -63457), 0);
    end
  end

  int cyc, tmax, tmin, pk_val, pk_first, pk_prev, pk_last;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (triangle > tmax) tmax = triangle;
      if (triangle < tmin) tmin = triangle;
      if (triangle == pk_val) begin
        if (pk_first < 0) pk_first = cyc;
        pk_prev = pk_last;
        pk_last = cyc;
      end
    end
  endtask

  initial begin
    int k, c0, c1;
    reset = 1'b1; cw_in = 1'b0; ccw_in = 1'b1; amplitude = 5'd1;
    pk_val = 1 << 20; pk_first = -1; pk_prev = 0; pk_last = 0;
    tmax = -100000; tmin = 100000; cyc = 0;
    repeat (3) @(negedge clk);
    check("reset_triangle", triangle, 0);
    check("reset_cw", cw_out, 0);
    check("reset_ccw", ccw_out, 0);

    // Unit amplitude, CCW from reset
    reset = 1'b0; cyc = 0; pk_val = 2047;
    run(3);
    check("ccw_first_crossing", ccw_out, 1);
    check("cw_idle", cw_out, 0);
    run(16380);
    check("peak_pos_amp1", tmax, 2047);
    check("peak_neg_amp1", tmin, -2047);
    check("first_peak_cycle", pk_first, 2048);
    check("period", pk_last - pk_prev, PERIOD);
    pk_val = 1 << 20;

    // Amplitude change mid-slope waits for the next zero crossing
    amplitude = 5'd31;
    run(1);
    check("amp_held_mid_slope", int'(triangle <= 2047 && triangle >= -2047), 1);
    run(4200);
    tmax = -100000; tmin = 100000;
    run(8200);
    check("peak_pos_amp31", tmax, 63457);
    check("peak_neg_amp31", tmin, -63457);

    // Both requests high -> immediate stop; then CW at a crossing
    cw_in = 1'b1;
    run(1);
    check("stop_cw", cw_out, 0);
    check("stop_ccw", ccw_out, 0);
    ccw_in = 1'b0;
    k = 0;
    while (cw_out !== 1'b1 && k < 8300) begin run(1); k++; end
    check("cw_start_timeout", int'(k >= 8300), 0);
    check("cw_start_at_zero", triangle, 0);

    // Reversal CW->CCW, then timed CCW->CW
    cw_in = 1'b0; ccw_in = 1'b1;
    k = 0;
    while (ccw_out !== 1'b1 && k < 8300) begin run(1); k++; end
    check("ccw_start_timeout", int'(k >= 8300), 0);
    cw_in = 1'b1; ccw_in = 1'b0;
    k = 0;
    while (ccw_out !== 1'b0 && k < 8300) begin run(1); k++; end
    check("rev_drop_timeout", int'(k >= 8300), 0);
    c0 = cyc; k = 0;
    while (cw_out !== 1'b1 && k < 100) begin run(1); k++; end
    c1 = cyc;
`ifdef AC_MOTOR_TRIANGLE_DEADTIME_EN
    check("reversal_gap", c1 - c0, 16);
`else
    check("reversal_gap", c1 - c0, 0);
`endif

    // Reset at phase +1000
    k = 0;
    while ((m_n % PERIOD) != 1000 && k < 8300) begin run(1); k++; end
    check("phase1000_timeout", int'(k >= 8300), 0);
    reset = 1'b1;
    run(1);
    check("midreset_triangle", triangle, 0);
    check("midreset_cw", cw_out, 0);
    check("midreset_ccw", ccw_out, 0);
    reset = 1'b0;
    run(3);
    check("restart_ramp", triangle, 2 * 31);

    // Randomized direction and amplitude segments
    for (int s = 0; s < 30; s++) begin
      cw_in     = 1'($urandom_range(0, 1));
      ccw_in    = 1'($urandom_range(0, 1));
      amplitude = 5'($urandom_range(0, 31));
      if (s % 3 == 0) run($urandom_range(1, 20));
      else            run($urandom_range(200, 1500));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
